clk_meas_ctrl: RTL

CLK_MEAS_CTRL -- requirements
Module: clk_meas_ctrl

---
 rtl/clk_meas_pkg.sv | 19 +
 rtl/clk_meas_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/clk_meas_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_meas_pkg : shared types and widths for the clock measurement ctrl |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package clk_meas_pkg;

    localparam int c_cnt_w = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RESTART = 3'd1,
        SETTLE  = 3'd2,
        SAMPLE  = 3'd3,
        RESP    = 3'd4
    } state_t;

endpackage : clk_meas_pkg
`default_nettype wire

// File: rtl/clk_meas_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_meas_ctrl : sequences an external high/low-time tester and       |
// | reports the first stable reading, or a timeout. Rev 1.0              |
// +----------------------------------------------------------------------+
module clk_meas_ctrl
    import clk_meas_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int RESTART_CYC = 2,
    parameter int SETTLE_CYC  = 64,
    parameter int SAMPLE_DIV  = 256,
    parameter int STABLE_CNT  = 4,
    parameter int TIMEOUT_CYC = 65535,
    localparam int c_sel_w    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk_fst,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [c_sel_w-1:0] req_ch,
    output logic [c_sel_w-1:0] tst_sel,
    output logic               tst_restart,
    input  logic [15:0]        tst_ht,
    input  logic [15:0]        tst_lt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [15:0]        rsp_ht,
    output logic [15:0]        rsp_lt,
    output logic [16:0]        rsp_period,
    output logic               rsp_err
);

    localparam int c_ph_max  = (SETTLE_CYC > RESTART_CYC) ? SETTLE_CYC : RESTART_CYC;
    localparam int c_ph_w    = $clog2(c_ph_max + 1);
    localparam int c_div_w   = $clog2(SAMPLE_DIV + 1);
    localparam int c_match_w = $clog2(STABLE_CNT + 1);
    localparam int c_to_w    = $clog2(TIMEOUT_CYC + 1);

    localparam logic [c_ph_w-1:0]    c_restart_last = c_ph_w'(RESTART_CYC - 1);
    localparam logic [c_ph_w-1:0]    c_settle_last  = c_ph_w'(SETTLE_CYC - 1);
    localparam logic [c_div_w-1:0]   c_div_last     = c_div_w'(SAMPLE_DIV - 1);
    localparam logic [c_match_w-1:0] c_stable_val   = c_match_w'(STABLE_CNT);
    localparam logic [c_to_w-1:0]    c_to_last      = c_to_w'(TIMEOUT_CYC - 1);

    state_t                 r_state, w_state;
    logic [c_ph_w-1:0]      r_phase_cnt, w_phase_cnt;
    logic [c_div_w-1:0]     r_div_cnt, w_div_cnt;
    logic [c_match_w-1:0]   r_match_cnt, w_match_cnt;
    logic [c_to_w-1:0]      r_to_cnt, w_to_cnt;
    logic [c_cnt_w-1:0]     r_snap_ht, w_snap_ht;
    logic [c_cnt_w-1:0]     r_snap_lt, w_snap_lt;

    logic                   w_req_ready;
    logic [c_sel_w-1:0]     w_tst_sel;
    logic                   w_tst_restart;
    logic                   w_rsp_valid;
    logic [c_cnt_w-1:0]     w_rsp_ht, w_rsp_lt;
    logic [c_cnt_w:0]       w_rsp_period;
    logic                   w_rsp_err;

    logic                   w_sample, w_match, w_stable, w_timeout;
    logic [c_match_w-1:0]   w_match_inc;

    always_comb begin
        w_state       = r_state;
        w_phase_cnt   = r_phase_cnt;
        w_div_cnt     = r_div_cnt;
        w_match_cnt   = r_match_cnt;
        w_to_cnt      = r_to_cnt;
        w_snap_ht     = r_snap_ht;
        w_snap_lt     = r_snap_lt;
        w_req_ready   = req_ready;
        w_tst_sel     = tst_sel;
        w_tst_restart = 1'b0;
        w_rsp_valid   = rsp_valid;
        w_rsp_ht      = rsp_ht;
        w_rsp_lt      = rsp_lt;
        w_rsp_period  = rsp_period;
        w_rsp_err     = rsp_err;

        // A zero count means the tester has not seen a full edge pair yet.
        w_sample    = (r_div_cnt == c_div_last);
        w_match     = (tst_ht == r_snap_ht) && (tst_lt == r_snap_lt) &&
                      (tst_ht != '0) && (tst_lt != '0);
        w_match_inc = r_match_cnt + 1'b1;
        w_stable    = w_sample && w_match && (w_match_inc == c_stable_val);
        w_timeout   = (r_to_cnt == c_to_last);

        case (r_state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    w_state       = RESTART;
                    w_req_ready   = 1'b0;
                    w_tst_restart = 1'b1;
                    w_phase_cnt   = '0;
                    w_tst_sel     = (int'(req_ch) < NUM_CH) ? req_ch : '0;
                end
            end
            RESTART: begin
                if (r_phase_cnt == c_restart_last) begin
                    w_state     = SETTLE;
                    w_phase_cnt = '0;
                end else begin
                    w_tst_restart = 1'b1;
                    w_phase_cnt   = r_phase_cnt + 1'b1;
                end
            end
            SETTLE: begin
                if (r_phase_cnt == c_settle_last) begin
                    w_state     = SAMPLE;
                    w_phase_cnt = '0;
                    w_div_cnt   = '0;
                    w_match_cnt = '0;
                    w_to_cnt    = '0;
                    w_snap_ht   = '0;
                    w_snap_lt   = '0;
                end else begin
                    w_phase_cnt = r_phase_cnt + 1'b1;
                end
            end
            SAMPLE: begin
                w_div_cnt = w_sample ? '0 : r_div_cnt + 1'b1;
                w_to_cnt  = r_to_cnt + 1'b1;
                if (w_sample) begin
                    if (w_match) begin
                        w_match_cnt = w_match_inc;
                    end else begin
                        w_snap_ht   = tst_ht;
                        w_snap_lt   = tst_lt;
                        w_match_cnt = '0;
                    end
                end
                // Stable wins over timeout; on timeout the pre-sample snapshot is reported.
                if (w_stable || w_timeout) begin
                    w_state      = RESP;
                    w_rsp_valid  = 1'b1;
                    w_rsp_ht     = r_snap_ht;
                    w_rsp_lt     = r_snap_lt;
                    w_rsp_period = {1'b0, r_snap_ht} + {1'b0, r_snap_lt};
                    w_rsp_err    = !w_stable;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state     = IDLE;
                    w_rsp_valid = 1'b0;
                    w_req_ready = 1'b1;
                end
            end
            default: begin
                w_state     = IDLE;
                w_req_ready = 1'b1;
                w_rsp_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_fst) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_phase_cnt <= '0;
            r_div_cnt   <= '0;
            r_match_cnt <= '0;
            r_to_cnt    <= '0;
            r_snap_ht   <= '0;
            r_snap_lt   <= '0;
            req_ready   <= 1'b1;
            tst_sel     <= '0;
            tst_restart <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_ht      <= '0;
            rsp_lt      <= '0;
            rsp_period  <= '0;
            rsp_err     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_phase_cnt <= w_phase_cnt;
            r_div_cnt   <= w_div_cnt;
            r_match_cnt <= w_match_cnt;
            r_to_cnt    <= w_to_cnt;
            r_snap_ht   <= w_snap_ht;
            r_snap_lt   <= w_snap_lt;
            req_ready   <= w_req_ready;
            tst_sel     <= w_tst_sel;
            tst_restart <= w_tst_restart;
            rsp_valid   <= w_rsp_valid;
            rsp_ht      <= w_rsp_ht;
            rsp_lt      <= w_rsp_lt;
            rsp_period  <= w_rsp_period;
            rsp_err     <= w_rsp_err;
        end
    end

endmodule : clk_meas_ctrl
`default_nettype wire
